// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, 11-clock frame, ACK check.
// Optional PS2_TX_RETRY_EN: retries a failed frame twice before reporting tx_err.
module ps2_host_tx #(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int INHIBIT_US  = 120,
  parameter int TIMEOUT_US  = 15000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy
`ifdef PS2_TX_RETRY_EN
  ,
  output logic [1:0] retry_cnt
`endif
);

  localparam int INHIBIT_CYC = CLK_FREQ_HZ / 1000000 * INHIBIT_US;
  localparam int TIMEOUT_CYC = CLK_FREQ_HZ / 1000000 * TIMEOUT_US;
  localparam int INH_W       = $clog2(INHIBIT_CYC);
  localparam int WD_W        = $clog2(TIMEOUT_CYC);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_INHIBIT   = 3'd1;
  localparam logic [2:0] S_REQ       = 3'd2;
  localparam logic [2:0] S_SHIFT     = 3'd3;
  localparam logic [2:0] S_ACK       = 3'd4;
  localparam logic [2:0] S_WAIT_IDLE = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [10:0]      frame_q, frame_d;
  logic [3:0]       bit_q, bit_d;
  logic [INH_W-1:0] inh_q, inh_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             clk_oe_q, clk_oe_d;
  logic             data_oe_q, data_oe_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [2:0]       clk_sync_q;
  logic [1:0]       data_sync_q;
  logic             fall, clk_s, data_s, fail;
  logic [3:0]       nxt_bit;
`ifdef PS2_TX_RETRY_EN
  logic [1:0]       retry_q, retry_d;
`endif

  // Sync flops reset high (idle bus) so reset release never fakes a falling edge.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_sync_q  <= 3'b111;
      data_sync_q <= 2'b11;
    end else begin
      clk_sync_q  <= {clk_sync_q[1:0], ps2_clk_in};
      data_sync_q <= {data_sync_q[0], ps2_data_in};
    end
  end

  assign clk_s   = clk_sync_q[1];
  assign data_s  = data_sync_q[1];
  assign fall    = clk_sync_q[2] & ~clk_sync_q[1];
  assign nxt_bit = bit_q + 4'd1;

  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    bit_d     = bit_q;
    inh_d     = inh_q;
    wd_d      = wd_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    fail      = 1'b0;
`ifdef PS2_TX_RETRY_EN
    retry_d   = retry_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (tx_valid) begin
          frame_d   = {1'b1, ~^tx_data, tx_data, 1'b0};
          inh_d     = '0;
          clk_oe_d  = 1'b1;
          data_oe_d = 1'b0;
          state_d   = S_INHIBIT;
`ifdef PS2_TX_RETRY_EN
          retry_d   = 2'd0;
`endif
        end
      end
      S_INHIBIT: begin
        inh_d = inh_q + INH_W'(1);
        if (inh_q == INH_W'(INHIBIT_CYC - 2)) data_oe_d = 1'b1;
        if (inh_q == INH_W'(INHIBIT_CYC - 1)) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b1;
          bit_d     = 4'd0;
          wd_d      = '0;
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        if (fall) begin
          data_oe_d = ~frame_q[1];
          bit_d     = 4'd1;
          state_d   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (fall) begin
          bit_d = nxt_bit;
          if (bit_q == 4'd9) begin
            data_oe_d = 1'b0;
            state_d   = S_ACK;
          end else begin
            data_oe_d = ~frame_q[nxt_bit];
          end
        end
      end
      S_ACK: begin
        if (fall) begin
          if (!data_s) state_d = S_WAIT_IDLE;
          else         fail    = 1'b1;
        end
      end
      S_WAIT_IDLE: begin
        if (clk_s && data_s) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Watchdog restarts on every device clock edge; a stalled device aborts the frame.
    if (state_q == S_REQ || state_q == S_SHIFT || state_q == S_ACK || state_q == S_WAIT_IDLE) begin
      if (fall)                                 wd_d = '0;
      else if (wd_q == WD_W'(TIMEOUT_CYC - 1)) fail = 1'b1;
      else                                      wd_d = wd_q + WD_W'(1);
    end

    if (fail) begin
      done_d    = 1'b0;
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
      state_d   = S_IDLE;
`ifdef PS2_TX_RETRY_EN
      if (retry_q != 2'd2) begin
        retry_d  = retry_q + 2'd1;
        inh_d    = '0;
        clk_oe_d = 1'b1;
        state_d  = S_INHIBIT;
      end else begin
        err_d = 1'b1;
      end
`else
      err_d = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q   <= S_IDLE;
      frame_q   <= '0;
      bit_q     <= '0;
      inh_q     <= '0;
      wd_q      <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      retry_q   <= 2'd0;
`endif
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      bit_q     <= bit_d;
      inh_q     <= inh_d;
      wd_q      <= wd_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      done_q    <= done_d;
      err_q     <= err_d;
`ifdef PS2_TX_RETRY_EN
      retry_q   <= retry_d;
`endif
    end
  end

  assign tx_ready    = (state_q == S_IDLE);
  assign busy        = ~tx_ready;
  assign tx_done     = done_q;
  assign tx_err      = err_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
`ifdef PS2_TX_RETRY_EN
  assign retry_cnt   = retry_q;
`endif

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a wired-AND PS/2 device model (80-cycle device clock).
module tb_ps2_host_tx;

  localparam int INHIBIT_CYC = 120;
  localparam int TIMEOUT_CYC = 2000;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_done, tx_err, ps2_clk_oe, ps2_data_oe, busy;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       ps2_clk_in, ps2_data_in;
`ifdef PS2_TX_RETRY_EN
  logic [1:0] retry_cnt;
`endif

  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(.CLK_FREQ_HZ(1000000), .INHIBIT_US(120), .TIMEOUT_US(2000)) dut (
    .clk(clk), .clrn(clrn), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_done(tx_done), .tx_err(tx_err),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe), .busy(busy)
`ifdef PS2_TX_RETRY_EN
    , .retry_cnt(retry_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int done_cnt = 0, err_cnt = 0, both_cnt = 0;
  int inh_runs = 0, last_inh = 0, run_len = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (tx_done) done_cnt++;
    if (tx_err) err_cnt++;
    if (tx_done && tx_err) both_cnt++;
    if (ps2_clk_oe) run_len++;
    else if (run_len != 0) begin
      last_inh = run_len;
      inh_runs++;
      run_len = 0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (busy && !ps2_clk_oe) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_err(output bit ok, output int n);
    ok = 1'b0;
    n  = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      n++;
      if (tx_err) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (tx_ready) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Device reads host data at the end of each clock-low phase.
  task automatic dev_pulse(output logic smp);
    @(negedge clk);
    dev_clk_low = 1'b1;
    tick(39);
    smp = ps2_data_in;
    @(negedge clk);
    dev_clk_low = 1'b0;
    tick(39);
  endtask

  task automatic dev_frame(input int nfalls, input bit ack_low, input bit poke,
                           output logic [10:0] bits, output int err_pre);
    logic b;
    bits = '0;
    tick(20);
    bits[0] = ps2_data_in;
    for (int i = 1; i <= 10 && i <= nfalls; i++) begin
      dev_pulse(b);
      bits[i] = b;
      if (poke && i == 3) begin
        @(negedge clk);
        tx_data  = 8'hAA;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
      end
    end
    err_pre = err_cnt;
    if (nfalls > 10) begin
      dev_data_low = ack_low;
      tick(10);
      dev_pulse(b);
      dev_data_low = 1'b0;
    end
  endtask

  initial begin
    bit ok;
    int d0, e0, r0, n, ep;
    logic [10:0] bits;

    tick(3);
    chk("reset_outputs", {tx_ready, tx_done, tx_err, ps2_clk_oe, ps2_data_oe, busy}, 6'b100000);
    clrn = 1'b1;
    tick(5);
    chk("idle_outputs", {tx_ready, tx_done, tx_err, ps2_clk_oe, ps2_data_oe, busy}, 6'b100000);

    // 0xED with ACK
    d0 = done_cnt; e0 = err_cnt; r0 = inh_runs;
    send(8'hED);
    chk("ready_after_accept", tx_ready, 1'b0);
    chk("clk_oe_in_inhibit", ps2_clk_oe, 1'b1);
    wait_req(ok);
    chk("ed_req_reached", ok, 1'b1);
    chk("ed_req_data_oe", ps2_data_oe, 1'b1);
    dev_frame(11, 1'b1, 1'b0, bits, ep);
    wait_idle(ok);
    tick(2);
    chk("ed_idle_reached", ok, 1'b1);
    chk("ed_inhibit_len", last_inh, INHIBIT_CYC);
    chk("ed_inhibit_runs", inh_runs - r0, 1);
    chk("ed_frame_bits", bits, 11'b11111011010);
    chk("ed_parity", bits[9], 1'b1);
    chk("ed_done_count", done_cnt - d0, 1);
    chk("ed_err_count", err_cnt - e0, 0);
    chk("ed_busy_after", busy, 1'b0);

    // 0xF4 with NACK; a 0xAA request mid-frame must be ignored
    d0 = done_cnt; e0 = err_cnt;
    send(8'hF4);
    wait_req(ok);
    chk("f4_req_reached", ok, 1'b1);
    dev_frame(11, 1'b0, 1'b1, bits, ep);
    tick(2);
    chk("f4_frame_bits", bits, 11'b10111101000);
    chk("f4_parity", bits[9], 1'b0);
    chk("f4_no_err_before_fall11", ep - e0, 0);
    chk("f4_err_count", err_cnt - e0, 1);
    chk("f4_done_count", done_cnt - d0, 0);
    chk("f4_ready_after", tx_ready, 1'b1);

    // 0x00 with a silent device: watchdog expiry
    send(8'h00);
    wait_req(ok);
    chk("to_req_reached", ok, 1'b1);
    wait_err(ok, n);
    chk("to_err_seen", ok, 1'b1);
    chk("to_cycles", n, TIMEOUT_CYC);
    chk("to_lines_released", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    chk("to_ready", tx_ready, 1'b1);

    // Reset in the middle of SHIFT
    send(8'h00);
    wait_req(ok);
    chk("rst_req_reached", ok, 1'b1);
    for (int i = 0; i < 3; i++) dev_pulse(bits[0]);
    d0 = done_cnt; e0 = err_cnt;
    @(negedge clk);
    clrn = 1'b0;
    #1;
    chk("rst_lines_released", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    tick(3);
    chk("rst_ready_busy", {tx_ready, busy}, 2'b10);
    clrn = 1'b1;
    tick(5);
    chk("rst_no_flags", (done_cnt - d0) + (err_cnt - e0), 0);

    // tx_valid held high: back-to-back frames each with a full inhibit
    r0 = inh_runs; e0 = err_cnt;
    @(negedge clk);
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    wait_err(ok, n);
    chk("b2b_first_err", ok, 1'b1);
    wait_req(ok);
    tx_valid = 1'b0;
    chk("b2b_second_req", ok, 1'b1);
    tick(2);
    chk("b2b_inhibit_runs", inh_runs - r0, 2);
    chk("b2b_inhibit_len", last_inh, INHIBIT_CYC);
    wait_err(ok, n);
    tick(2);
    chk("b2b_second_err", ok, 1'b1);
    chk("b2b_idle", tx_ready, 1'b1);

`ifdef PS2_TX_RETRY_EN
    // Two NACKs then ACK for 0xFF
    d0 = done_cnt; e0 = err_cnt; r0 = inh_runs;
    send(8'hFF);
    for (int a = 0; a < 3; a++) begin
      wait_req(ok);
      chk("rty_req_reached", ok, 1'b1);
      dev_frame(11, (a == 2), 1'b0, bits, ep);
    end
    wait_idle(ok);
    tick(2);
    chk("rty_frame_bits", bits, 11'b11111111110);
    chk("rty_inhibit_runs", inh_runs - r0, 3);
    chk("rty_done_count", done_cnt - d0, 1);
    chk("rty_err_count", err_cnt - e0, 0);
    chk("rty_retry_cnt", retry_cnt, 2'd2);
`endif

    chk("done_err_overlap", both_cnt, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
